dice_roll_controller: RTL and testbench
=======================================

// Module: dice_roll_controller
// PURPOSE
//  Sequences one die roll for the dice game. While the roll button is held, the die
//  value steps 1..6 at a fast fixed rate. On release, the stepping slows through a
//  fixed number of steps with lengthening intervals, then settles and signals DONE.
//  Sits between the debounced button input and the score/display logic.
// PARAMETERS
//  TICK_DIV    4  clock cycles per die step while ROLLING (>=1)
//  SLOW_STEPS  3  number of die steps taken in SLOWING (>=1)
//  SLOW_INC    2  cycles added to the step interval after every step (ROLLING->SLOWING and in SLOWING)
//  INT_W       8  width of interval/tick counters; TICK_DIV+(SLOW_STEPS+1)*SLOW_INC < 2**INT_W
// PORTS
//  CLK        in   1  system clock
//  RESET      in   1  synchronous, active-high reset
//  ROLL_BTN   in   1  debounced roll button, level (1 = held)
//  DIE_VALUE  out  3  current die face, 1..6
//  BUSY       out  1  1 while in ROLLING or SLOWING
//  DONE       out  1  one-cycle pulse: DIE_VALUE is the final result
// BEHAVIOUR
//  - All outputs and state are registered and update on posedge CLK only.
//  - RESET=1 (any state, any cycle): state=IDLE, DIE_VALUE=1, BUSY=0, DONE=0, tick_cnt=0,
//    step_cnt=0, interval=TICK_DIV, btn_q=0. RESET has priority over every other event.
//  - btn_q is ROLL_BTN registered each cycle; press = ROLL_BTN & ~btn_q.
//  - States (2-bit): IDLE, ROLLING, SLOWING, SETTLED.
//  - IDLE: on a press, go to ROLLING with tick_cnt=0 and interval=TICK_DIV. A level held
//    from before (no rising edge) never starts a roll.
//  - Tick: in ROLLING and SLOWING, tick_cnt increments every cycle. When tick_cnt==interval-1,
//    tick_cnt<=0 and DIE_VALUE advances (6 wraps to 1). With defaults, the first advance is
//    on the 4th clock in ROLLING.
//  - ROLLING: if ROLL_BTN==0, go to SLOWING with interval<=TICK_DIV+SLOW_INC, step_cnt<=0,
//    tick_cnt<=0. If the release and a tick fall on the same cycle, the die advances in that
//    cycle too.
//  - SLOWING: ROLL_BTN is ignored. On each tick: advance the die, step_cnt++, and
//    interval+=SLOW_INC. On the tick where step_cnt==SLOW_STEPS-1, go to SETTLED.
//  - SETTLED: lasts exactly 1 cycle with DONE=1 and DIE_VALUE frozen, then go to IDLE.
//  - BUSY = (state==ROLLING || state==SLOWING), registered with the state.
//  - DIE_VALUE holds its value in IDLE and SETTLED. It is never 0 or 7 outside reset.
//  - Roll length is unbounded while the button is held. The counters never overflow,
//    because tick_cnt resets on every tick.
// TESTING
//  1. Assert RESET for 2 cycles -> DIE_VALUE=1, BUSY=0, DONE=0, and DONE stays 0 while idle.
//  2. Defaults. Press and hold for 20 cycles -> BUSY rises 1 cycle after the press. The die
//     advances every 4 cycles (1->2->3->4->5 after 16 ROLLING cycles) and wraps 6->1.
//  3. Release after exactly 5 advances (DIE=6). The slow steps come 6, 8 and 10 cycles apart
//     (DIE 1, 2, 3). Then DONE=1 for 1 cycle with DIE_VALUE=3, BUSY=0, and the next cycle is IDLE.
//  4. Hold ROLL_BTN through SETTLED and into IDLE -> no new roll. Release and press again ->
//     a new roll starts and the first advance is 4 cycles later.
//  5. Assert RESET for 1 cycle mid-SLOWING -> next cycle is IDLE with DIE_VALUE=1 and BUSY=0.
//     DONE never pulses for the aborted roll.
//  6. Release on the same cycle as a tick (DIE 3->4) -> the advance happens, SLOWING starts,
//     and the first slow step comes 6 cycles later (DIE=5). Also toggle ROLL_BTN in SLOWING ->
//     no effect on timing.

Source files
------------

// File: rtl/dice_roll_controller.sv
// Sequences one die roll: fast stepping while the roll button is held, then a
// fixed number of slowing steps with lengthening intervals, then a one-cycle DONE.
module dice_roll_controller #(
    parameter int TICK_DIV   = 4,
    parameter int SLOW_STEPS = 3,
    parameter int SLOW_INC   = 2,
    parameter int INT_W      = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ROLL_BTN,
    output logic [2:0] DIE_VALUE,
    output logic       BUSY,
    output logic       DONE
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROLLING = 2'd1,
        SLOWING = 2'd2,
        SETTLED = 2'd3
    } state_t;

    localparam logic [INT_W-1:0] TICK_DIV_C  = INT_W'(TICK_DIV);
    localparam logic [INT_W-1:0] SLOW_INC_C  = INT_W'(SLOW_INC);
    localparam logic [INT_W-1:0] SLOW_LAST_C = INT_W'(SLOW_STEPS - 1);
    localparam logic [INT_W-1:0] CNT_ZERO_C  = {INT_W{1'b0}};
    localparam logic [INT_W-1:0] CNT_ONE_C   = INT_W'(1);
    localparam logic [2:0]       FACE_ONE_C  = 3'd1;

    state_t           state_r, state_s;
    logic [2:0]       die_r, die_s;
    logic [INT_W-1:0] tick_cnt_r, tick_cnt_s;
    logic [INT_W-1:0] step_cnt_r, step_cnt_s;
    logic [INT_W-1:0] interval_r, interval_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             btn_q_r;
    logic             press_s;
    logic             tick_s;

    // Advance a die face 1..6 with wrap; any illegal code recovers to 1.
    function automatic logic [2:0] next_face(input logic [2:0] face);
        logic [2:0] nxt;
        if ((face >= 3'd6) || (face == 3'd0)) begin
            nxt = FACE_ONE_C;
        end else begin
            nxt = face + 3'd1;
        end
        return nxt;
    endfunction

    assign press_s   = ROLL_BTN & ~btn_q_r;
    assign tick_s    = (tick_cnt_r == (interval_r - CNT_ONE_C));
    assign DIE_VALUE = die_r;
    assign BUSY      = busy_r;
    assign DONE      = done_r;

    // State, counters and registered outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r    <= IDLE;
            die_r      <= FACE_ONE_C;
            tick_cnt_r <= CNT_ZERO_C;
            step_cnt_r <= CNT_ZERO_C;
            interval_r <= TICK_DIV_C;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            btn_q_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            die_r      <= die_s;
            tick_cnt_r <= tick_cnt_s;
            step_cnt_r <= step_cnt_s;
            interval_r <= interval_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            btn_q_r    <= ROLL_BTN;
        end
    end

    // Next-state, counter and output decode.
    always_comb begin
        state_s    = state_r;
        die_s      = die_r;
        tick_cnt_s = tick_cnt_r;
        step_cnt_s = step_cnt_r;
        interval_s = interval_r;
        busy_s     = 1'b0;
        done_s     = 1'b0;

        case (state_r)
            IDLE: begin
                if (press_s) begin
                    state_s    = ROLLING;
                    tick_cnt_s = CNT_ZERO_C;
                    interval_s = TICK_DIV_C;
                    busy_s     = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end

            ROLLING: begin
                busy_s = 1'b1;
                if (tick_s) begin
                    tick_cnt_s = CNT_ZERO_C;
                    die_s      = next_face(die_r);
                end else begin
                    tick_cnt_s = tick_cnt_r + CNT_ONE_C;
                end
                // Release wins over the tick counter but keeps a coincident advance.
                if (!ROLL_BTN) begin
                    state_s    = SLOWING;
                    interval_s = TICK_DIV_C + SLOW_INC_C;
                    step_cnt_s = CNT_ZERO_C;
                    tick_cnt_s = CNT_ZERO_C;
                end else begin
                    state_s = ROLLING;
                end
            end

            SLOWING: begin
                busy_s = 1'b1;
                if (tick_s) begin
                    tick_cnt_s = CNT_ZERO_C;
                    die_s      = next_face(die_r);
                    step_cnt_s = step_cnt_r + CNT_ONE_C;
                    interval_s = interval_r + SLOW_INC_C;
                    if (step_cnt_r == SLOW_LAST_C) begin
                        state_s = SETTLED;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                    end else begin
                        state_s = SLOWING;
                    end
                end else begin
                    tick_cnt_s = tick_cnt_r + CNT_ONE_C;
                    state_s    = SLOWING;
                end
            end

            SETTLED: begin
                state_s = IDLE;
            end

            default: begin
                state_s = IDLE;
                die_s   = FACE_ONE_C;
            end
        endcase
    end

endmodule

// File: tb/tb_dice_roll_controller.sv
// Directed bench for dice_roll_controller with default parameters; expected
// die values and timings are hand-derived from the roll sequencing rules.
module tb_dice_roll_controller;

    logic       CLK;
    logic       RESET;
    logic       ROLL_BTN;
    logic [2:0] DIE_VALUE;
    logic       BUSY;
    logic       DONE;

    int n_assert;
    int n_fail;

    dice_roll_controller dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .ROLL_BTN  (ROLL_BTN),
        .DIE_VALUE (DIE_VALUE),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] die, input logic busy, input logic done);
        chk({tag, ".die"},  {5'd0, DIE_VALUE}, {5'd0, die});
        chk({tag, ".busy"}, {7'd0, BUSY},      {7'd0, busy});
        chk({tag, ".done"}, {7'd0, DONE},      {7'd0, done});
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        RESET    = 1'b1;
        ROLL_BTN = 1'b0;

        // Reset and idle
        tick_n(2);
        chk_all("reset", 3'd1, 1'b0, 1'b0);
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick_n(1);
            chk_all("idle", 3'd1, 1'b0, 1'b0);
        end

        // Press and hold: one advance per 4 cycles
        ROLL_BTN = 1'b1;
        chk("pre_press.busy", {7'd0, BUSY}, 8'd0);
        tick_n(1);
        chk_all("press", 3'd1, 1'b1, 1'b0);
        tick_n(3);
        chk("roll3.die", {5'd0, DIE_VALUE}, 8'd1);
        tick_n(1);
        chk("roll4.die", {5'd0, DIE_VALUE}, 8'd2);
        tick_n(12);
        chk("roll16.die", {5'd0, DIE_VALUE}, 8'd5);
        tick_n(4);
        chk("roll20.die", {5'd0, DIE_VALUE}, 8'd6);

        // Release: slow steps 6, 8, 10 cycles apart, then DONE
        ROLL_BTN = 1'b0;
        tick_n(1);
        chk_all("release", 3'd6, 1'b1, 1'b0);
        tick_n(5);
        chk("slow1_pre.die", {5'd0, DIE_VALUE}, 8'd6);
        tick_n(1);
        chk("slow1.die", {5'd0, DIE_VALUE}, 8'd1);
        tick_n(7);
        chk("slow2_pre.die", {5'd0, DIE_VALUE}, 8'd1);
        tick_n(1);
        chk("slow2.die", {5'd0, DIE_VALUE}, 8'd2);
        tick_n(9);
        chk_all("slow3_pre", 3'd2, 1'b1, 1'b0);
        tick_n(1);
        chk_all("settled", 3'd3, 1'b0, 1'b1);
        tick_n(1);
        chk_all("after_settled", 3'd3, 1'b0, 1'b0);

        // Second roll from 3 with wrap, button held through SLOWING and SETTLED
        ROLL_BTN = 1'b1;
        tick_n(1);
        chk_all("r2_press", 3'd3, 1'b1, 1'b0);
        tick_n(3);
        chk("r2_roll3.die", {5'd0, DIE_VALUE}, 8'd3);
        tick_n(1);
        chk("r2_roll4.die", {5'd0, DIE_VALUE}, 8'd4);
        tick_n(8);
        chk("r2_roll12.die", {5'd0, DIE_VALUE}, 8'd6);
        tick_n(4);
        chk("r2_wrap.die", {5'd0, DIE_VALUE}, 8'd1);
        ROLL_BTN = 1'b0;
        tick_n(1);
        chk_all("r2_release", 3'd1, 1'b1, 1'b0);
        ROLL_BTN = 1'b1;
        tick_n(5);
        chk("r2_slow1_pre.die", {5'd0, DIE_VALUE}, 8'd1);
        tick_n(1);
        chk("r2_slow1.die", {5'd0, DIE_VALUE}, 8'd2);
        ROLL_BTN = 1'b0;
        tick_n(3);
        ROLL_BTN = 1'b1;
        tick_n(5);
        chk("r2_slow2.die", {5'd0, DIE_VALUE}, 8'd3);
        tick_n(10);
        chk_all("r2_settled", 3'd4, 1'b0, 1'b1);
        tick_n(1);
        chk_all("r2_idle", 3'd4, 1'b0, 1'b0);
        tick_n(3);
        chk_all("held_no_roll", 3'd4, 1'b0, 1'b0);
        ROLL_BTN = 1'b0;
        tick_n(1);
        chk("r3_released.busy", {7'd0, BUSY}, 8'd0);
        ROLL_BTN = 1'b1;
        tick_n(1);
        chk_all("r3_press", 3'd4, 1'b1, 1'b0);
        tick_n(3);
        chk("r3_roll3.die", {5'd0, DIE_VALUE}, 8'd4);
        tick_n(1);
        chk("r3_roll4.die", {5'd0, DIE_VALUE}, 8'd5);

        // Reset mid-SLOWING aborts without DONE
        ROLL_BTN = 1'b0;
        tick_n(1);
        chk_all("r3_release", 3'd5, 1'b1, 1'b0);
        tick_n(3);
        RESET = 1'b1;
        tick_n(1);
        chk_all("abort_reset", 3'd1, 1'b0, 1'b0);
        RESET = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick_n(1);
            chk_all("abort_idle", 3'd1, 1'b0, 1'b0);
        end

        // Release coincident with a tick; button toggling in SLOWING ignored
        ROLL_BTN = 1'b1;
        tick_n(1);
        chk_all("r4_press", 3'd1, 1'b1, 1'b0);
        tick_n(11);
        chk("r4_roll11.die", {5'd0, DIE_VALUE}, 8'd3);
        ROLL_BTN = 1'b0;
        tick_n(1);
        chk_all("r4_release_tick", 3'd4, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            ROLL_BTN = ~ROLL_BTN;
            tick_n(1);
        end
        chk_all("r4_slow1_pre", 3'd4, 1'b1, 1'b0);
        ROLL_BTN = ~ROLL_BTN;
        tick_n(1);
        chk("r4_slow1.die", {5'd0, DIE_VALUE}, 8'd5);
        for (int i = 0; i < 7; i++) begin
            ROLL_BTN = ~ROLL_BTN;
            tick_n(1);
        end
        chk("r4_slow2_pre.die", {5'd0, DIE_VALUE}, 8'd5);
        ROLL_BTN = ~ROLL_BTN;
        tick_n(1);
        chk("r4_slow2.die", {5'd0, DIE_VALUE}, 8'd6);
        ROLL_BTN = 1'b0;
        tick_n(9);
        chk_all("r4_slow3_pre", 3'd6, 1'b1, 1'b0);
        tick_n(1);
        chk_all("r4_settled", 3'd1, 1'b0, 1'b1);
        tick_n(1);
        chk_all("r4_idle", 3'd1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
